scan_decoder: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with enable and three operating modes. LEVEL holds a decoded select, PULSE emits a timed strobe, and SCAN auto-walks all outputs with a programmable dwell. It sits between control logic issuing channel indices and downstream per-channel enables or strobes. It replaces hand-built fixed-width combinational decoders wherever glitch-free, timed, or sequenced selects are needed.

---
 rtl/scan_decoder_pkg.sv | 30 +++
 rtl/scan_decoder_if.sv | 38 +++
 rtl/scan_decoder_onehot.sv | 21 ++
 rtl/scan_decoder.sv | 149 ++++++++++++++
 tb/tb_scan_decoder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Purpose  : Shared types for the scan_decoder block: operating-mode and
//             controller-state encodings plus default parameter values.
//  Revision : 1.0  initial release
// ============================================================================
package decoder_pkg;

    // Operating mode as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Controller state; width fixed at 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_PULSE = 2'b10,
        ST_SCAN  = 2'b11
    } state_e;

    localparam int C_SEL_W_DEF   = 3;
    localparam int C_DWELL_W_DEF = 8;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : scan_decoder_if
//  Purpose  : Control/select bundle between an index-issuing master and the
//             scan_decoder. The master drives enable, mode, index and dwell;
//             the decoder returns ready and the registered select outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface scan_decoder_if
    import decoder_pkg::*;
#(
    parameter int SEL_W   = C_SEL_W_DEF,
    parameter int DWELL_W = C_DWELL_W_DEF
);
    localparam int N_OUT = 2 ** SEL_W;

    logic               en;
    mode_e              mode;
    logic [SEL_W-1:0]   din;
    logic               din_valid;
    logic               din_ready;
    logic [DWELL_W-1:0] dwell;
    logic [N_OUT-1:0]   dout;
    logic               active;
    logic               scan_wrap;

    modport master (
        output en, mode, din, din_valid, dwell,
        input  din_ready, dout, active, scan_wrap
    );

    modport slave (
        input  en, mode, din, din_valid, dwell,
        output din_ready, dout, active, scan_wrap
    );

endinterface : scan_decoder_if
`default_nettype wire

// File: rtl/scan_decoder_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_dec
//  Purpose  : Purely combinational binary index to one-hot vector mapper.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel_i,
    output logic [2**SEL_W-1:0]   oh_o
);

    // Set exactly the bit addressed by sel_i.
    always_comb begin
        oh_o        = '0;
        oh_o[sel_i] = 1'b1;
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : scan_decoder
//  Purpose  : Registered binary-to-one-hot decoder with enable and three
//             modes: LEVEL (held select), PULSE (dwell+1 cycle strobe) and
//             SCAN (walks every output, dwell+1 cycles each, wrap pulse).
//  Revision : 1.0  initial release
// ============================================================================
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W   = C_SEL_W_DEF,
    parameter int DWELL_W = C_DWELL_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    scan_decoder_if.slave     bus
);

    localparam int N_OUT = 2 ** SEL_W;

    state_e             state_q, state_d;
    mode_e              mode_q;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0]   dout_q, dout_d;
    logic               active_q, active_d;
    logic               wrap_q, wrap_d;

    logic               w_mode_chg;
    logic               w_force_idle;
    logic               w_ready;
    logic               w_accept;
    logic [SEL_W-1:0]   w_dec_sel;
    logic [N_OUT-1:0]   w_oh;

    // A mode switch is only meaningful while enabled; it costs one idle cycle.
    assign w_mode_chg   = (bus.mode != mode_q);
    assign w_force_idle = !bus.en || w_mode_chg || (bus.mode == MODE_RSVD);

    // Ready is withheld during a mode-change cycle because that cycle always
    // lands in IDLE, so an index presented then could not be honoured.
    assign w_ready  = bus.en && !rst && !w_mode_chg &&
                      ((bus.mode == MODE_LEVEL) ||
                       ((bus.mode == MODE_PULSE) && (state_q != ST_PULSE)));
    assign w_accept = bus.din_valid && w_ready;

    // Single decoder shared by all modes: SCAN decodes the walking index,
    // LEVEL/PULSE decode the incoming index.
    assign w_dec_sel = (state_d == ST_SCAN) ? idx_d : bus.din;

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel_i (w_dec_sel),
        .oh_o  (w_oh)
    );

    // State, counters and registered outputs; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_LEVEL;
            idx_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= bus.mode;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state: mode sequencing, pulse countdown and scan walk.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (w_force_idle) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (bus.mode)
                MODE_LEVEL: begin
                    if (w_accept) begin
                        state_d = ST_HOLD;
                    end
                end
                MODE_PULSE: begin
                    if (state_q == ST_PULSE) begin
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - DWELL_W'(1);
                        end
                    end else if (w_accept) begin
                        state_d = ST_PULSE;
                        cnt_d   = bus.dwell;
                    end
                end
                MODE_SCAN: begin
                    if (state_q != ST_SCAN) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        cnt_d   = bus.dwell;
                    end else if (cnt_q == '0) begin
                        // Natural SEL_W-bit wrap gives modulo N_OUT.
                        idx_d = idx_q + SEL_W'(1);
                        cnt_d = bus.dwell;
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output next values, derived from the state being entered.
    always_comb begin
        dout_d = dout_q;
        case (state_d)
            ST_IDLE:  dout_d = '0;
            ST_HOLD:  if (w_accept) dout_d = w_oh;
            ST_PULSE: if (state_q != ST_PULSE) dout_d = w_oh;
            ST_SCAN:  dout_d = w_oh;
            default:  dout_d = '0;
        endcase
        active_d = |dout_d;
        wrap_d   = (state_q == ST_SCAN) && (state_d == ST_SCAN) &&
                   (cnt_q == '0) && (&idx_q);
    end

    assign bus.din_ready = w_ready;
    assign bus.dout      = dout_q;
    assign bus.active    = active_q;
    assign bus.scan_wrap = wrap_q;

endmodule : scan_decoder
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_decoder
//  Purpose  : Self-checking bench for scan_decoder. Two instances (SEL_W=3,
//             DWELL_W=8 and SEL_W=4, DWELL_W=2) share one stimulus stream and
//             are compared every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_decoder;
    import decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    bit       s_rst   = 1'b1;
    bit       s_en    = 1'b0;
    bit       s_valid = 1'b0;
    bit [1:0] s_mode  = 2'd0;
    bit [3:0] s_din   = 4'd0;
    bit [7:0] s_dwell = 8'd0;

    scan_decoder_if #(.SEL_W(3), .DWELL_W(8)) bus_a ();
    scan_decoder_if #(.SEL_W(4), .DWELL_W(2)) bus_b ();

    assign rst             = s_rst;
    assign bus_a.en        = s_en;
    assign bus_a.mode      = mode_e'(s_mode);
    assign bus_a.din       = s_din[2:0];
    assign bus_a.din_valid = s_valid;
    assign bus_a.dwell     = s_dwell;
    assign bus_b.en        = s_en;
    assign bus_b.mode      = mode_e'(s_mode);
    assign bus_b.din       = s_din;
    assign bus_b.din_valid = s_valid;
    assign bus_b.dwell     = s_dwell[1:0];

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    scan_decoder #(.SEL_W(4), .DWELL_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [15:0] dout_a16, dout_b16;
    assign dout_a16 = {8'h00, bus_a.dout};
    assign dout_b16 = bus_b.dout;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Behavioural model per instance: which output is lit (-1 none), what is
    // going on (0 nothing, 1 level hold, 2 strobe, 3 scan), cycles left for
    // the current output, scan position, last seen mode, wrap flag.
    int m_out  [2] = '{-1, -1};
    int m_kind [2] = '{0, 0};
    int m_left [2] = '{0, 0};
    int m_pos  [2] = '{0, 0};
    int m_prev [2] = '{0, 0};
    bit m_wrap [2] = '{1'b0, 1'b0};

    function automatic bit exp_ready(int k);
        return s_en && !s_rst && (int'(s_mode) == m_prev[k]) &&
               (s_mode == 2'd0 || (s_mode == 2'd1 && m_kind[k] != 2));
    endfunction

    task automatic check(string name, int k, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, k, $time, got, exp);
        end
    endtask

    task automatic lit(string name, logic [15:0] got, logic [15:0] exp);
        check(name, 0, got, exp);
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model advance on every rising edge from the inputs present at that edge.
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int nout, dw, d;
            bit rdy;
            nout = (k == 0) ? 8 : 16;
            dw   = (k == 0) ? int'(s_dwell) : int'(s_dwell[1:0]);
            d    = (k == 0) ? int'(s_din[2:0]) : int'(s_din);
            rdy  = exp_ready(k);
            if (s_rst) begin
                m_out[k] = -1; m_kind[k] = 0; m_left[k] = 0;
                m_pos[k] = 0;  m_prev[k] = 0; m_wrap[k] = 1'b0;
            end else begin
                m_wrap[k] = 1'b0;
                if (!s_en || int'(s_mode) != m_prev[k] || s_mode == 2'd3) begin
                    m_out[k] = -1; m_kind[k] = 0;
                end else if (s_mode == 2'd0) begin
                    if (s_valid && rdy) begin
                        m_out[k] = d; m_kind[k] = 1;
                    end
                end else if (s_mode == 2'd1) begin
                    if (m_kind[k] == 2) begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_out[k] = -1; m_kind[k] = 0;
                        end
                    end else if (s_valid && rdy) begin
                        m_out[k] = d; m_kind[k] = 2; m_left[k] = dw + 1;
                    end
                end else begin
                    if (m_kind[k] != 3) begin
                        m_kind[k] = 3; m_pos[k] = 0; m_left[k] = dw + 1; m_out[k] = 0;
                    end else begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_pos[k]  = (m_pos[k] + 1) % nout;
                            m_left[k] = dw + 1;
                            m_out[k]  = m_pos[k];
                            m_wrap[k] = (m_pos[k] == 0);
                        end
                    end
                end
                m_prev[k] = int'(s_mode);
            end
        end
        if (s_rst) chk_on = 1'b1;
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                logic [15:0] exp_v;
                exp_v = (m_out[k] < 0) ? 16'h0000 : (16'd1 << m_out[k]);
                check("dout", k, (k == 0) ? dout_a16 : dout_b16, exp_v);
                check("active", k, {15'd0, (k == 0) ? bus_a.active : bus_b.active},
                      {15'd0, m_out[k] >= 0});
                check("scan_wrap", k, {15'd0, (k == 0) ? bus_a.scan_wrap : bus_b.scan_wrap},
                      {15'd0, m_wrap[k]});
                check("din_ready", k, {15'd0, (k == 0) ? bus_a.din_ready : bus_b.din_ready},
                      {15'd0, exp_ready(k)});
            end
        end
    end

    initial begin
        logic [7:0] e8;
        cyc(3);
        lit("reset_dout", dout_a16, 16'h0000);
        lit("reset_active", {15'd0, bus_a.active}, 16'h0000);
        lit("reset_wrap", {15'd0, bus_a.scan_wrap}, 16'h0000);
        lit("reset_ready", {15'd0, bus_a.din_ready}, 16'h0000);
        s_rst = 1'b0;

        // LEVEL: 5 then 2
        s_en = 1'b1; s_mode = 2'd0; cyc(1);
        s_valid = 1'b1; s_din = 4'd5; cyc(1); s_valid = 1'b0;
        lit("level_5", dout_a16, 16'h0020);
        lit("level_active", {15'd0, bus_a.active}, 16'h0001);
        check("model_level", 0, 16'(m_out[0]), 16'd5);
        cyc(2);
        lit("level_hold", dout_a16, 16'h0020);
        s_valid = 1'b1; s_din = 4'd2; cyc(1); s_valid = 1'b0;
        lit("level_2", dout_a16, 16'h0004);

        // PULSE: dwell=3, din=7, valid held throughout
        s_mode = 2'd1; cyc(1);
        lit("pulse_modechg", dout_a16, 16'h0000);
        s_valid = 1'b1; s_din = 4'd7; s_dwell = 8'd3; cyc(1);
        lit("pulse_on", dout_a16, 16'h0080);
        lit("pulse_rdy_low", {15'd0, bus_a.din_ready}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            lit("pulse_hold", dout_a16, 16'h0080);
            lit("pulse_rdy_hold", {15'd0, bus_a.din_ready}, 16'h0000);
        end
        cyc(1);
        lit("pulse_off", dout_a16, 16'h0000);
        lit("pulse_rdy_back", {15'd0, bus_a.din_ready}, 16'h0001);
        cyc(1);
        lit("pulse_again", dout_a16, 16'h0080);
        s_valid = 1'b0; cyc(4);
        lit("pulse_again_off", dout_a16, 16'h0000);

        // SCAN: dwell=1
        s_dwell = 8'd1; s_mode = 2'd2; cyc(1);
        lit("scan_modechg", dout_a16, 16'h0000);
        cyc(1);
        lit("scan_entry", dout_a16, 16'h0001);
        for (int k = 1; k < 34; k++) begin
            cyc(1);
            e8 = 8'd1 << ((k / 2) % 8);
            lit("scan_walk", dout_a16, {8'h00, e8});
            lit("scan_wrap_t", {15'd0, bus_a.scan_wrap}, {15'd0, (k == 16 || k == 32)});
        end

        // LEVEL -> SCAN while holding din=4
        s_mode = 2'd0; cyc(1);
        s_valid = 1'b1; s_din = 4'd4; cyc(1);
        lit("chg_level", dout_a16, 16'h0010);
        s_mode = 2'd2; cyc(1);
        lit("chg_gap", dout_a16, 16'h0000);
        cyc(1); s_valid = 1'b0;
        lit("chg_scan0", dout_a16, 16'h0001);

        // reset mid-scan at idx 6
        cyc(12);
        lit("scan_idx6", dout_a16, 16'h0040);
        s_rst = 1'b1; cyc(1);
        lit("rst_dout", dout_a16, 16'h0000);
        lit("rst_active", {15'd0, bus_a.active}, 16'h0000);
        s_rst = 1'b0; cyc(1);
        lit("rst_gap", dout_a16, 16'h0000);
        cyc(1);
        lit("rst_restart", dout_a16, 16'h0001);

        // en dropped mid-pulse, then fresh strobe
        s_mode = 2'd1; cyc(1);
        s_dwell = 8'd5; s_din = 4'd3; s_valid = 1'b1; cyc(1); s_valid = 1'b0;
        lit("enp_on", dout_a16, 16'h0008);
        cyc(1);
        s_en = 1'b0; cyc(1);
        lit("enp_drop", dout_a16, 16'h0000);
        s_en = 1'b1; s_valid = 1'b1; s_din = 4'd1; cyc(1); s_valid = 1'b0;
        lit("enp_fresh", dout_a16, 16'h0002);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            lit("enp_hold", dout_a16, 16'h0002);
        end
        cyc(1);
        lit("enp_end", dout_a16, 16'h0000);

        // dwell all ones: 256-cycle strobe
        s_dwell = 8'hFF; s_din = 4'd0; s_valid = 1'b1; cyc(1); s_valid = 1'b0;
        cyc(255);
        lit("max_last", dout_a16, 16'h0001);
        cyc(1);
        lit("max_end", dout_a16, 16'h0000);

        // reserved mode
        s_mode = 2'd3; s_valid = 1'b1; cyc(2);
        lit("rsvd_dout", dout_a16, 16'h0000);
        lit("rsvd_ready", {15'd0, bus_a.din_ready}, 16'h0000);
        s_valid = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) s_en = !s_en;
            else if (!s_en && $urandom_range(0, 3) == 0) s_en = 1'b1;
            if ($urandom_range(0, 39) == 0) s_mode = 2'($urandom_range(0, 3));
            s_valid = 1'($urandom_range(0, 1));
            s_din   = 4'($urandom);
            if ($urandom_range(0, 9) == 0)
                s_dwell = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            cyc(1);
        end
        s_rst = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scan_decoder
`default_nettype wire
